// File: rtl/trackball_pkg.sv
`default_nettype none
// ============================================================================
// Module : trackball_pkg
// Desc   : Shared defaults and width helpers for the trackball pulse counter.
// Rev    : 1.0
// ============================================================================
package trackball_pkg;

  localparam int c_DEF_CNT_WIDTH   = 4;
  localparam int c_DEF_SYNC_STAGES = 2;
  localparam int c_DEF_MIN_PERIOD  = 16;

  // Pending needs one extra bit so it can hold +/-(2^CNT_WIDTH - 1).
  function automatic int pend_width(input int cnt_width);
    return cnt_width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trackball_axis.sv
`default_nettype none
// ============================================================================
// Module : trackball_axis
// Desc   : One trackball axis: sync, edge holdoff, step, hold/pending, count.
// Rev    : 1.0
// ============================================================================
module trackball_axis
  import trackball_pkg::*;
#(
  parameter int CNT_WIDTH   = c_DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = c_DEF_SYNC_STAGES,
  parameter int MIN_PERIOD  = c_DEF_MIN_PERIOD
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pulse_clk,
  input  logic                 pulse_dir,
  input  logic                 flip,
  input  logic                 rd_hold,
  input  logic                 cnt_clr,
  input  logic                 settling,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 sign
);

  localparam int c_PW = pend_width(CNT_WIDTH);
  localparam int c_HW = $clog2(MIN_PERIOD + 1);
  localparam logic signed [c_PW-1:0] c_PEND_MAX = c_PW'((1 << CNT_WIDTH) - 1);
  localparam logic signed [c_PW-1:0] c_PEND_MIN = -c_PEND_MAX;
  localparam logic signed [c_PW-1:0] c_PEND_ONE = c_PW'(1);
  localparam logic [c_HW-1:0]        c_HOLDOFF  = c_HW'(MIN_PERIOD);

  logic [SYNC_STAGES-1:0] r_sync_clk;
  logic [SYNC_STAGES-1:0] r_sync_dir;
  logic                   r_prev;
  logic [c_HW-1:0]        r_holdoff;
  logic signed [c_PW-1:0] r_pending;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   r_sign;

  logic                 w_clk_s;
  logic                 w_dir_s;
  logic                 w_edge;
  logic                 w_accept;
  logic                 w_up;
  logic [CNT_WIDTH-1:0] w_step;

  assign w_clk_s  = r_sync_clk[SYNC_STAGES-1];
  assign w_dir_s  = r_sync_dir[SYNC_STAGES-1];
  assign w_edge   = w_clk_s ^ r_prev;
  // A clear discards the edge entirely, so it neither arms holdoff nor moves sign.
  assign w_accept = w_edge && !settling && (r_holdoff == '0) && !cnt_clr;
  assign w_up     = (w_dir_s == flip);
  assign w_step   = w_accept ? (w_up ? CNT_WIDTH'(1) : '1) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_clk <= '0;
      r_sync_dir <= '0;
      r_prev     <= 1'b0;
      r_holdoff  <= '0;
      r_pending  <= '0;
      r_count    <= '0;
      r_sign     <= 1'b0;
    end else begin
      r_sync_clk <= {r_sync_clk[SYNC_STAGES-2:0], pulse_clk};
      r_sync_dir <= {r_sync_dir[SYNC_STAGES-2:0], pulse_dir};
      r_prev     <= w_clk_s;

      if (w_accept) begin
        r_holdoff <= c_HOLDOFF;
        r_sign    <= ~w_up;
      end else if (r_holdoff != '0) begin
        r_holdoff <= r_holdoff - c_HW'(1);
      end

      if (cnt_clr) begin
        r_count   <= '0;
        r_pending <= '0;
      end else if (rd_hold) begin
        // Saturate rather than wrap so a long read never reverses the motion.
        if (w_accept && w_up && (r_pending != c_PEND_MAX)) begin
          r_pending <= r_pending + c_PEND_ONE;
        end else if (w_accept && !w_up && (r_pending != c_PEND_MIN)) begin
          r_pending <= r_pending - c_PEND_ONE;
        end
      end else begin
        r_count   <= r_count + r_pending[CNT_WIDTH-1:0] + w_step;
        r_pending <= '0;
      end
    end
  end

  assign count = r_count;
  assign sign  = r_sign;

endmodule
`default_nettype wire

// File: rtl/trackball_counter.sv
`default_nettype none
// ============================================================================
// Module : trackball_counter
// Desc   : Dual-axis up/down counter fed by trackball emulator pulse pairs.
// Rev    : 1.0
// ============================================================================
module trackball_counter
  import trackball_pkg::*;
#(
  parameter int CNT_WIDTH   = c_DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = c_DEF_SYNC_STAGES,
  parameter int MIN_PERIOD  = c_DEF_MIN_PERIOD
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 h_clk,
  input  logic                 h_dir,
  input  logic                 v_clk,
  input  logic                 v_dir,
  input  logic                 flip,
  input  logic                 rd_hold,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] h_count,
  output logic [CNT_WIDTH-1:0] v_count,
  output logic                 h_sign,
  output logic                 v_sign
);

  localparam int              c_SETTLE_CYCLES = SYNC_STAGES + 1;
  localparam int              c_SW            = $clog2(c_SETTLE_CYCLES + 1);
  localparam logic [c_SW-1:0] c_SETTLE_LAST   = c_SW'(c_SETTLE_CYCLES);

  logic [c_SW-1:0] r_settle;
  logic            w_settling;

  // Edges are ignored until the sync chains have flushed the reset-time level.
  assign w_settling = (r_settle != c_SETTLE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_settle <= '0;
    end else if (w_settling) begin
      r_settle <= r_settle + c_SW'(1);
    end
  end

  trackball_axis #(
    .CNT_WIDTH   (CNT_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_h_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .pulse_clk (h_clk),
    .pulse_dir (h_dir),
    .flip      (flip),
    .rd_hold   (rd_hold),
    .cnt_clr   (cnt_clr),
    .settling  (w_settling),
    .count     (h_count),
    .sign      (h_sign)
  );

  trackball_axis #(
    .CNT_WIDTH   (CNT_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_v_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .pulse_clk (v_clk),
    .pulse_dir (v_dir),
    .flip      (flip),
    .rd_hold   (rd_hold),
    .cnt_clr   (cnt_clr),
    .settling  (w_settling),
    .count     (v_count),
    .sign      (v_sign)
  );

endmodule
`default_nettype wire

// File: tb/tb_trackball_counter.sv
`default_nettype none
// ============================================================================
// Module : tb_trackball_counter
// Desc   : Self-checking bench for trackball_counter against a cycle model.
// Rev    : 1.0
// ============================================================================
module tb_trackball_counter;

  localparam int CW   = 4;
  localparam int SS   = 2;
  localparam int MP   = 16;
  localparam int MOD  = 1 << CW;
  localparam int PMAX = MOD - 1;
  localparam int MAXN = 20000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          h_clk = 1'b0, h_dir = 1'b0, v_clk = 1'b0, v_dir = 1'b0;
  logic          flip = 1'b0, rd_hold = 1'b0, cnt_clr = 1'b0;
  logic [CW-1:0] h_count, v_count;
  logic          h_sign, v_sign;

  trackball_counter #(
    .CNT_WIDTH   (CW),
    .SYNC_STAGES (SS),
    .MIN_PERIOD  (MP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .h_clk   (h_clk),
    .h_dir   (h_dir),
    .v_clk   (v_clk),
    .v_dir   (v_dir),
    .flip    (flip),
    .rd_hold (rd_hold),
    .cnt_clr (cnt_clr),
    .h_count (h_count),
    .v_count (v_count),
    .h_sign  (h_sign),
    .v_sign  (v_sign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: input samples per edge since reset release; the logic sees the
  // clk/dir value captured SS edges earlier and compares it with one edge before.
  int mn = 0;
  bit hist_clk [2][MAXN+1];
  bit hist_dir [2][MAXN+1];
  int m_cnt  [2];
  int m_pend [2];
  int m_last [2];
  bit m_sign [2];

  function automatic bit seen_clk(input int a, input int k);
    return (k >= 1 && k <= MAXN) ? hist_clk[a][k] : 1'b0;
  endfunction

  function automatic bit seen_dir(input int a, input int k);
    return (k >= 1 && k <= MAXN) ? hist_dir[a][k] : 1'b0;
  endfunction

  task automatic model_reset();
    mn = 0;
    for (int a = 0; a < 2; a++) begin
      m_cnt[a]  = 0;
      m_pend[a] = 0;
      m_last[a] = -1000000;
      m_sign[a] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit acc, up;
    int st;
    mn++;
    if (mn <= MAXN) begin
      hist_clk[0][mn] = h_clk;  hist_dir[0][mn] = h_dir;
      hist_clk[1][mn] = v_clk;  hist_dir[1][mn] = v_dir;
    end
    for (int a = 0; a < 2; a++) begin
      if (cnt_clr) begin
        m_cnt[a]  = 0;
        m_pend[a] = 0;
      end else begin
        acc = (seen_clk(a, mn - SS) != seen_clk(a, mn - SS - 1)) &&
              (mn > SS + 1) && (mn - m_last[a] > MP);
        st = 0;
        if (acc) begin
          up        = (seen_dir(a, mn - SS) == flip);
          m_last[a] = mn;
          m_sign[a] = !up;
          st        = up ? 1 : -1;
        end
        if (rd_hold) begin
          m_pend[a] = m_pend[a] + st;
          if (m_pend[a] >  PMAX) m_pend[a] =  PMAX;
          if (m_pend[a] < -PMAX) m_pend[a] = -PMAX;
        end else begin
          m_cnt[a]  = (((m_cnt[a] + m_pend[a] + st) % MOD) + MOD) % MOD;
          m_pend[a] = 0;
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      check("h_count", h_count, m_cnt[0]);
      check("h_sign",  h_sign,  m_sign[0]);
      check("v_count", v_count, m_cnt[1]);
      check("v_sign",  v_sign,  m_sign[1]);
    end
  end

  // Returns at posedge+2 so every drive is well clear of the sampling edge.
  task automatic step_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic tgl_h(input int gap);
    h_clk = ~h_clk;
    step_clks(gap);
  endtask

  task automatic tgl_v(input int gap);
    v_clk = ~v_clk;
    step_clks(gap);
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    step_clks(1);
    cnt_clr = 1'b0;
    step_clks(1);
  endtask

  task automatic lit(input string name, input int act, input int exp);
    @(negedge clk);
    check(name, act, exp);
  endtask

  int r;

  initial begin
    model_reset();
    // Reset with the pulse input already high.
    h_clk = 1'b1;
    #1;
    check("reset_h_count", h_count, 0);
    check("reset_v_sign", v_sign, 0);
    step_clks(3);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    step_clks(20);
    @(negedge clk); check("idle_h_count", h_count, 0); check("idle_h_sign", h_sign, 0);
    step_clks(1);

    // Wrap upward then downward.
    repeat (17) tgl_h(20);
    @(negedge clk); check("wrap_up", h_count, 1);
    step_clks(1);
    pulse_clr();
    h_dir = 1'b1;
    step_clks(4);
    repeat (17) tgl_h(20);
    @(negedge clk); check("wrap_dn", h_count, 15); check("wrap_dn_sign", h_sign, 1);
    step_clks(1);

    // Flip inverts direction; closely spaced toggles are dropped.
    h_dir = 1'b0;
    flip  = 1'b1;
    v_dir = 1'b0;
    step_clks(4);
    repeat (3) tgl_v(20);
    @(negedge clk); check("flip_v_count", v_count, 13); check("flip_v_sign", v_sign, 1);
    step_clks(1);
    flip = 1'b0;
    pulse_clr();
    step_clks(4);
    repeat (3) tgl_v(5);
    step_clks(20);
    @(negedge clk); check("glitch_v_count", v_count, 1); check("glitch_v_sign", v_sign, 0);
    step_clks(1);

    // Hold then release on the same cycle as an accepted edge.
    pulse_clr();
    step_clks(20);
    rd_hold = 1'b1;
    repeat (5) tgl_h(20);
    @(negedge clk); check("hold_frozen", h_count, 0);
    step_clks(1);
    h_clk = ~h_clk;
    step_clks(SS);
    rd_hold = 1'b0;
    @(negedge clk); check("pre_release", h_count, 0);
    @(negedge clk); check("release_plus6", h_count, 6);
    step_clks(20);

    // Pending saturation, then clear on an accepted edge during hold.
    pulse_clr();
    rd_hold = 1'b1;
    repeat (20) tgl_h(20);
    rd_hold = 1'b0;
    step_clks(2);
    @(negedge clk); check("sat_release", h_count, 15);
    step_clks(1);
    rd_hold = 1'b1;
    repeat (2) tgl_h(20);
    h_clk = ~h_clk;
    step_clks(SS);
    cnt_clr = 1'b1;
    step_clks(1);
    cnt_clr = 1'b0;
    @(negedge clk); check("clr_on_edge", h_count, 0);
    step_clks(20);
    rd_hold = 1'b0;
    step_clks(5);
    @(negedge clk); check("pending_cleared", h_count, 0);
    step_clks(1);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)                 h_clk = ~h_clk;
      r = $urandom_range(0, 99);
      if (r < 8)                 v_clk = ~v_clk;
      if ($urandom_range(0, 99) < 4) h_dir = ~h_dir;
      if ($urandom_range(0, 99) < 4) v_dir = ~v_dir;
      if ($urandom_range(0, 99) < 2) flip = ~flip;
      if ($urandom_range(0, 99) < 5) rd_hold = ~rd_hold;
      cnt_clr = ($urandom_range(0, 199) == 0);
      step_clks(1);
    end
    cnt_clr = 1'b0;
    rd_hold = 1'b0;
    step_clks(30);

    // Reset in the middle of a hold with pending movement.
    flip  = 1'b0;
    h_dir = 1'b0;
    v_dir = 1'b0;
    pulse_clr();
    step_clks(20);
    repeat (2) tgl_h(20);
    flip = 1'b1;
    tgl_v(20);
    flip = 1'b0;
    @(negedge clk); check("pre_rst_h", h_count, 2); check("pre_rst_v", v_count, 15);
    step_clks(1);
    rd_hold = 1'b1;
    repeat (3) tgl_h(20);
    reset_n = 1'b0;
    #1;
    check("rst_h_count", h_count, 0);
    check("rst_v_count", v_count, 0);
    check("rst_h_sign", h_sign, 0);
    check("rst_v_sign", v_sign, 0);
    h_clk   = 1'b1;
    v_clk   = 1'b1;
    rd_hold = 1'b0;
    step_clks(3);
    reset_n = 1'b1;
    step_clks(20);
    @(negedge clk); check("settle_h", h_count, 0); check("settle_v", v_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
